// File: rtl/awb_stat_accum_pkg.sv
// Shared ISP definitions for the AWB statistics path:
// FSM encoding, RGB888 field positions and statistic widths.
package awb_stat_accum_pkg;

    localparam int STAT_W = 64;
    localparam int CNT_W  = 32;
    localparam int PIX_W  = 24;
    localparam int CH_W   = 8;
    localparam int K_W    = 10;

    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_ACCUM   = 2'd2
    } awb_state_t;

    function automatic logic [CH_W-1:0] chan(
        input logic [PIX_W-1:0] px,
        input int               lsb
    );
        return px[lsb +: CH_W];
    endfunction

endpackage

// File: rtl/awb_sat_acc64.sv
// 64-bit saturating accumulator; a clear may load the
// coincident sample so no pixel is lost at a frame boundary.
module awb_sat_acc64
    import awb_stat_accum_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              add_en,
    input  logic [IN_W-1:0]   add_val,
    output logic [STAT_W-1:0] acc
);

    logic [STAT_W-1:0] add_ext;
    logic [STAT_W:0]   sum;

    assign add_ext = {{(STAT_W-IN_W){1'b0}}, add_val};
    assign sum     = {1'b0, acc} + {1'b0, add_ext};

    // clear (optionally loading the new sample) or add, pinning at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= add_en ? add_ext : '0;
        end else if (add_en) begin
            acc <= sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
        end
    end

endmodule

// File: rtl/awb_stat_accum.sv
// Per-frame R/G/B/K sums and pixel count for auto white balance,
// latched at each vsync rising edge once a full frame was seen.
module awb_stat_accum
    import awb_stat_accum_pkg::*;
#(
    parameter logic [7:0]  SAT_TH = 8'd255,
    parameter int unsigned K_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stat_en,
    input  logic              vsync,
    input  logic              de,
    input  logic [PIX_W-1:0]  pix_data,
    output logic [STAT_W-1:0] r_sum,
    output logic [STAT_W-1:0] g_sum,
    output logic [STAT_W-1:0] b_sum,
    output logic [STAT_W-1:0] k_sum,
    output logic [CNT_W-1:0]  pix_cnt,
    output logic              frame_done,
    output logic              stats_valid
);

    logic              vsync_r;
    logic              vs_d;
    logic              de_r;
    logic [PIX_W-1:0]  pix_r;
    logic              vs_edge;
    awb_state_t        state;
    awb_state_t        state_nxt;
    logic [CH_W-1:0]   r_ch;
    logic [CH_W-1:0]   g_ch;
    logic [CH_W-1:0]   b_ch;
    logic [K_W-1:0]    k_val;
    logic              pix_ok;
    logic              in_acc;
    logic              accept;
    logic              clr;
    logic              latch;
    logic [STAT_W-1:0] r_acc;
    logic [STAT_W-1:0] g_acc;
    logic [STAT_W-1:0] b_acc;
    logic [STAT_W-1:0] k_acc;
    logic [STAT_W-1:0] k_lat;
    logic [CNT_W-1:0]  cnt_acc;

    // register the video inputs once and keep the previous vsync
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r <= 1'b0;
            vs_d    <= 1'b0;
            de_r    <= 1'b0;
            pix_r   <= '0;
        end else begin
            vsync_r <= vsync;
            vs_d    <= vsync_r;
            de_r    <= de;
            pix_r   <= pix_data;
        end
    end

    assign vs_edge = vsync_r & ~vs_d;

    assign r_ch = chan(pix_r, R_LSB);
    assign g_ch = chan(pix_r, G_LSB);
    assign b_ch = chan(pix_r, B_LSB);

    assign pix_ok = (r_ch < SAT_TH) && (g_ch < SAT_TH) && (b_ch < SAT_TH);

    if (K_MODE == 0) begin : g_k_green
        assign k_val = {2'b00, g_ch};
        assign k_lat = k_acc;
    end else begin : g_k_luma
        assign k_val = {2'b00, r_ch} + {1'b0, g_ch, 1'b0} + {2'b00, b_ch};
        assign k_lat = k_acc >> 2;
    end

    // frame tracking state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // arm on enable, start accumulating on the first frame boundary
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    state_nxt = ST_WAIT_VS;
            ST_WAIT_VS: if (vs_edge) state_nxt = ST_ACCUM;
            ST_ACCUM:   state_nxt = ST_ACCUM;
            default:    state_nxt = ST_IDLE;
        endcase
        if (!stat_en) state_nxt = ST_IDLE;
    end

    // the boundary pixel opens the new frame, also on the arming edge
    assign in_acc = (state == ST_ACCUM);
    assign accept = stat_en & de_r & pix_ok &
                    (in_acc | ((state == ST_WAIT_VS) & vs_edge));
    assign clr    = ~stat_en | ~in_acc | vs_edge;
    assign latch  = stat_en & in_acc & vs_edge & (cnt_acc != '0);

    awb_sat_acc64 #(.IN_W(CH_W)) u_r (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .add_en(accept), .add_val(r_ch), .acc(r_acc)
    );

    awb_sat_acc64 #(.IN_W(CH_W)) u_g (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .add_en(accept), .add_val(g_ch), .acc(g_acc)
    );

    awb_sat_acc64 #(.IN_W(CH_W)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .add_en(accept), .add_val(b_ch), .acc(b_acc)
    );

    awb_sat_acc64 #(.IN_W(K_W)) u_k (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .add_en(accept), .add_val(k_val), .acc(k_acc)
    );

    // accepted pixel counter, pinned at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_acc <= '0;
        end else if (clr) begin
            cnt_acc <= accept ? CNT_W'(1) : '0;
        end else if (accept && (cnt_acc != '1)) begin
            cnt_acc <= cnt_acc + CNT_W'(1);
        end
    end

    // publish the finished frame and pulse frame_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            g_sum       <= '0;
            b_sum       <= '0;
            k_sum       <= '0;
            pix_cnt     <= '0;
            frame_done  <= 1'b0;
            stats_valid <= 1'b0;
        end else begin
            frame_done <= latch;
            if (latch) begin
                r_sum       <= r_acc;
                g_sum       <= g_acc;
                b_sum       <= b_acc;
                k_sum       <= k_lat;
                pix_cnt     <= cnt_acc;
                stats_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_awb_stat_accum.sv
// Bench for awb_stat_accum: directed frame table, corner sequences
// and random frames against a frame-level reference model.
module tb_awb_stat_accum;
    import awb_stat_accum_pkg::*;

    typedef struct packed {
        logic [63:0] r;
        logic [63:0] g;
        logic [63:0] b;
        logic [63:0] k;
        logic [31:0] c;
    } res_t;

    typedef struct {
        int   due;
        res_t v;
    } exp_t;

    typedef struct {
        logic [23:0] pa;
        int          na;
        logic [23:0] pb;
        int          nb;
        bit          d;
        res_t        e0;
        res_t        e1;
    } row_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stat_en = 1'b0;
    logic        vsync = 1'b0;
    logic        de = 1'b0;
    logic [23:0] pix_data = '0;

    logic [63:0] o0_r, o0_g, o0_b, o0_k;
    logic [31:0] o0_c;
    logic        o0_fd, o0_sv;
    logic [63:0] o1_r, o1_g, o1_b, o1_k;
    logic [31:0] o1_c;
    logic        o1_fd, o1_sv;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int   th [2] = '{255, 200};
    int   km [2] = '{0, 1};
    exp_t q0 [$];
    exp_t q1 [$];
    res_t last [2];
    bit   has_last [2];
    bit   armed [2];
    logic [63:0] mr [2];
    logic [63:0] mg [2];
    logic [63:0] mb [2];
    logic [63:0] mk [2];
    logic [31:0] mc [2];
    bit   prev_vs;

    row_t rows [5];

    always #5 clk = ~clk;

    awb_stat_accum #(.SAT_TH(8'd255), .K_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .stat_en(stat_en),
        .vsync(vsync), .de(de), .pix_data(pix_data),
        .r_sum(o0_r), .g_sum(o0_g), .b_sum(o0_b),
        .k_sum(o0_k), .pix_cnt(o0_c),
        .frame_done(o0_fd), .stats_valid(o0_sv)
    );

    awb_stat_accum #(.SAT_TH(8'd200), .K_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .stat_en(stat_en),
        .vsync(vsync), .de(de), .pix_data(pix_data),
        .r_sum(o1_r), .g_sum(o1_g), .b_sum(o1_b),
        .k_sum(o1_k), .pix_cnt(o1_c),
        .frame_done(o1_fd), .stats_valid(o1_sv)
    );

    function automatic res_t mk_res(longint r, longint g, longint b,
                                    longint k, int c);
        res_t v;
        v.r = 64'(r);
        v.g = 64'(g);
        v.b = 64'(b);
        v.k = 64'(k);
        v.c = 32'(c);
        return v;
    endfunction

    function automatic res_t act(int i);
        res_t v;
        if (i == 0) v = mk_res(o0_r, o0_g, o0_b, o0_k, o0_c);
        else        v = mk_res(o1_r, o1_g, o1_b, o1_k, o1_c);
        return v;
    endfunction

    function automatic int ch(logic [23:0] p, int s);
        logic [23:0] t;
        t = p >> s;
        return int'(t[7:0]);
    endfunction

    task automatic report(string nm, int i, res_t a, res_t e);
        bad++;
        $display("FAIL %s dut%0d cyc%0d got r=%0d g=%0d b=%0d k=%0d n=%0d want r=%0d g=%0d b=%0d k=%0d n=%0d",
                 nm, i, cyc, a.r, a.g, a.b, a.k, a.c,
                 e.r, e.g, e.b, e.k, e.c);
    endtask

    task automatic m_clear(int i);
        mr[i] = 0; mg[i] = 0; mb[i] = 0; mk[i] = 0; mc[i] = 0;
    endtask

    task automatic model_reset();
        prev_vs = 1'b0;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            armed[i] = 1'b0;
            has_last[i] = 1'b0;
            last[i] = '0;
            m_clear(i);
        end
    endtask

    // frame bookkeeping: frames are split at vsync rising edges,
    // the first edge after enable only starts the first frame
    task automatic model_sample(bit en, bit vs, bit d, logic [23:0] px);
        bit   e;
        exp_t x;
        int   r, g, b;
        e = vs && !prev_vs;
        prev_vs = vs;
        r = ch(px, 16);
        g = ch(px, 8);
        b = ch(px, 0);
        for (int i = 0; i < 2; i++) begin
            if (!en) begin
                armed[i] = 1'b0;
                m_clear(i);
                continue;
            end
            if (e) begin
                if (armed[i] && mc[i] != 0) begin
                    x.due = cyc + 1;
                    x.v = mk_res(mr[i], mg[i], mb[i],
                                 (km[i] == 0) ? mk[i] : (mk[i] >> 2), mc[i]);
                    if (i == 0) q0.push_back(x);
                    else        q1.push_back(x);
                end
                m_clear(i);
                armed[i] = 1'b1;
            end
            if (armed[i] && d && r < th[i] && g < th[i] && b < th[i]) begin
                mr[i] += 64'(r);
                mg[i] += 64'(g);
                mb[i] += 64'(b);
                mk[i] += (km[i] == 0) ? 64'(g) : 64'(r + 2 * g + b);
                mc[i] += 1;
            end
        end
    endtask

    task automatic check_cycle();
        bit   fd, sv, due;
        exp_t h;
        res_t a;
        for (int i = 0; i < 2; i++) begin
            fd = (i == 0) ? o0_fd : o1_fd;
            sv = (i == 0) ? o0_sv : o1_sv;
            a = act(i);
            due = 1'b0;
            if (i == 0 && q0.size() > 0 && q0[0].due == cyc) begin
                due = 1'b1;
                h = q0.pop_front();
            end
            if (i == 1 && q1.size() > 0 && q1[0].due == cyc) begin
                due = 1'b1;
                h = q1.pop_front();
            end
            total++;
            if (fd !== due) begin
                bad++;
                $display("FAIL frame_done dut%0d cyc%0d got %0b want %0b",
                         i, cyc, fd, due);
            end
            if (due) begin
                last[i] = h.v;
                has_last[i] = 1'b1;
            end
            total++;
            if (a !== last[i]) report("outputs", i, a, last[i]);
            total++;
            if (sv !== has_last[i]) begin
                bad++;
                $display("FAIL stats_valid dut%0d cyc%0d got %0b want %0b",
                         i, cyc, sv, has_last[i]);
            end
        end
    endtask

    task automatic step(bit en, bit vs, bit d, logic [23:0] px);
        @(negedge clk);
        stat_en = en;
        vsync = vs;
        de = d;
        pix_data = px;
        cyc++;
        model_sample(en, vs, d, px);
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    task automatic check_reset();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (act(i) !== '0) report("reset_outputs", i, act(i), '0);
            total++;
            if (((i == 0) ? {o0_fd, o0_sv} : {o1_fd, o1_sv}) !== 2'b00) begin
                bad++;
                $display("FAIL reset_flags dut%0d got fd/sv=%0b%0b want 00",
                         i, (i == 0) ? o0_fd : o1_fd,
                         (i == 0) ? o0_sv : o1_sv);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset();
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic pulse(int w);
        step(1, 1, 0, 24'h0);
        for (int k = 1; k < w; k++) step(1, 1, 0, 24'h0);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 24'h0);
    endtask

    task automatic send_frame(row_t rw);
        for (int k = 0; k < rw.na; k++) step(1, 0, rw.d, rw.pa);
        step(1, 0, 0, 24'h0);
        for (int k = 0; k < rw.nb; k++) step(1, 0, rw.d, rw.pb);
        step(1, 0, 0, 24'h0);
        step(1, 0, 0, 24'h0);
        pulse(2);
    endtask

    function automatic logic [7:0] rnd_ch();
        case ($urandom % 8)
            0:       return 8'd255;
            1:       return 8'd200;
            2:       return 8'd199;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic logic [23:0] rnd_px();
        return {rnd_ch(), rnd_ch(), rnd_ch()};
    endfunction

    task automatic expect_val(string nm, longint a, longint e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s got %0d want %0d", nm, a, e);
        end
    endtask

    initial begin
        rows[0] = '{24'h102030, 4, 24'h0, 0, 1'b1,
                    mk_res(64, 128, 192, 128, 4),
                    mk_res(64, 128, 192, 128, 4)};
        rows[1] = '{24'h408020, 4, 24'h0, 0, 1'b1,
                    mk_res(256, 512, 128, 512, 4),
                    mk_res(256, 512, 128, 352, 4)};
        rows[2] = '{24'hFF1010, 2, 24'h101010, 2, 1'b1,
                    mk_res(32, 32, 32, 32, 2),
                    mk_res(32, 32, 32, 32, 2)};
        rows[3] = '{24'h123456, 4, 24'h0, 0, 1'b0,
                    mk_res(32, 32, 32, 32, 2),
                    mk_res(32, 32, 32, 32, 2)};
        rows[4] = '{24'hC81010, 2, 24'hC71010, 1, 1'b1,
                    mk_res(599, 48, 48, 48, 3),
                    mk_res(199, 16, 16, 61, 1)};

        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // partial frame before the arming edge must be ignored
        for (int k = 0; k < 4; k++) step(1, 0, 0, 24'h0);
        for (int k = 0; k < 3; k++) step(1, 0, 1, 24'h102030);
        pulse(2);

        for (int j = 0; j < 5; j++) begin
            send_frame(rows[j]);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (act(i) !== ((i == 0) ? rows[j].e0 : rows[j].e1))
                    report($sformatf("row%0d", j), i, act(i),
                           (i == 0) ? rows[j].e0 : rows[j].e1);
            end
        end
        expect_val("valid_after_empty", o0_sv, 1);

        // pixel in the edge cycle opens the next frame
        step(1, 1, 1, 24'h010203);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 24'h0);
        pulse(1);
        expect_val("edge_pix_cnt", o0_c, 1);
        expect_val("edge_pix_r", o0_r, 1);

        // enable drop mid-frame, then reset mid-frame
        for (int k = 0; k < 3; k++) step(1, 0, 1, 24'h111111);
        step(0, 0, 1, 24'h111111);
        step(0, 0, 0, 24'h0);
        expect_val("dis_cnt_acc", u0.cnt_acc, 0);
        expect_val("dis_r_acc", u0.r_acc, 0);
        expect_val("dis_hold_cnt", o0_c, 1);
        expect_val("dis_hold_valid", o0_sv, 1);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 24'h0);
        for (int k = 0; k < 3; k++) step(1, 0, 1, 24'h222222);
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 0, 1, 24'h030303);
        pulse(2);
        expect_val("rst_no_early_fd", o0_sv, 0);
        step(1, 0, 1, 24'h050505);
        step(1, 0, 1, 24'h050505);
        pulse(2);
        expect_val("rst_first_frame", o0_r, 10);

        // random frames
        for (int f = 0; f < 40; f++) begin
            int len = $urandom_range(8, 40);
            bit quiet = (f % 7 == 3);
            if (f % 13 == 6) begin
                for (int k = 0; k < 3; k++) step(0, 0, 1, rnd_px());
                for (int k = 0; k < 3; k++) step(1, 0, 1, rnd_px());
            end
            for (int k = 0; k < len; k++)
                step(1, 0, !quiet && ($urandom % 10 < 7), rnd_px());
            step(1, 1, $urandom % 2, rnd_px());
            for (int k = 1; k < $urandom_range(1, 3); k++)
                step(1, 1, $urandom % 2, rnd_px());
        end
        for (int k = 0; k < 4; k++) step(1, 0, 0, 24'h0);

        total++;
        if (q0.size() + q1.size() != 0) begin
            bad++;
            $display("FAIL pending_frames got %0d want 0",
                     q0.size() + q1.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
